// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared decode constants, ALU op encoding and the per-stage control word for the 5-stage core.
// A bubble is the all-zero control word, so clearing a stage register is enough to insert one.
package pipe_ctrl_unit_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [2:0] F3_BYTE  = 3'b000;
  localparam logic [2:0] F3_WORD  = 3'b010;
  localparam logic [2:0] F3_ADD   = 3'b000;

  localparam logic [6:0] F7_ADD   = 7'b0000000;
  localparam logic [6:0] F7_SUB   = 7'b0100000;
  localparam logic [6:0] F7_MUL   = 7'b0000001;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_MUL = 3'd2
  } aluop_e;

  typedef struct packed {
    logic   valid;
    logic   regwrite;
    logic   memwrite;
    logic   load;
    logic   byte_sz;
    logic   alusrc;
    logic   memtoreg;
    logic   mul;
    aluop_e aluop;
  } ctrl_t;

  typedef struct packed {
    logic  illegal;
    ctrl_t ctrl;
  } dstage_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  function automatic logic is_valid_mul(ctrl_t c);
    return c.valid & c.mul;
  endfunction

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Instruction fields, hazard-unit controls and per-stage control outputs of the control unit.
// slave = the control unit, master = whoever drives F and the hazard signals.
interface pipe_ctrl_unit_if;
  logic       instr_vld_f;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       stall_d;
  logic       flush_d;
  logic       flush_e;

  logic       load_d;
  logic       byte_d;
  logic       valid_d;
  logic       illegal_d;
  logic       alusrc_e;
  logic       mul_e;
  logic       valid_e;
  logic [2:0] aluop_e;
  logic       memwrite_m;
  logic       byte_m;
  logic       valid_m;
  logic       regwrite_w;
  logic       memtoreg_w;
  logic       byte_w;
  logic       valid_w;
  logic       mul_busy;

  modport slave (
    input  instr_vld_f, opcode, funct3, funct7, stall_d, flush_d, flush_e,
    output load_d, byte_d, valid_d, illegal_d,
    output alusrc_e, mul_e, valid_e, aluop_e,
    output memwrite_m, byte_m, valid_m,
    output regwrite_w, memtoreg_w, byte_w, valid_w,
    output mul_busy
  );

  modport master (
    output instr_vld_f, opcode, funct3, funct7, stall_d, flush_d, flush_e,
    input  load_d, byte_d, valid_d, illegal_d,
    input  alusrc_e, mul_e, valid_e, aluop_e,
    input  memwrite_m, byte_m, valid_m,
    input  regwrite_w, memtoreg_w, byte_w, valid_w,
    input  mul_busy
  );
endinterface

// File: rtl/pipe_ctrl_unit_ctrl_stage_reg.sv
// One pipeline stage register: clr inserts a bubble (beats en), en=0 holds, 1-cycle latency.
// Bubble is all-zero, shared with the synchronous active-low reset value.
module ctrl_stage_reg #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q;
  logic [W-1:0] stage_d;

  always_comb begin
    stage_d = stage_q;
    if (clr_i) begin
      stage_d = '0;
    end else if (en_i) begin
      stage_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Control decoder plus D/E/M/W control pipeline; 1 cycle per stage, MUL occupies E for MUL_LAT cycles.
// Backpressure: stall_d/mul_busy hold D, mul_busy holds E and bubbles M; flushes bubble D or E.
module pipe_ctrl_unit
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  pipe_ctrl_unit_if.slave       bus
);

  ctrl_t      dec_ctrl;
  logic       dec_illegal;
  dstage_t    dec_word;

  dstage_t    d_q;
  ctrl_t      e_q;
  ctrl_t      m_q;
  ctrl_t      w_q;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             mul_busy;
  logic             mul_enter;
  logic             mul_abort;

  logic d_en, d_clr, e_en, e_clr, m_clr;

  // F-stage decode; an invalid slot is a plain bubble, an unknown encoding keeps valid but no ctrl.
  always_comb begin
    dec_ctrl    = CTRL_BUBBLE;
    dec_illegal = 1'b0;
    if (bus.instr_vld_f) begin
      dec_ctrl.valid = 1'b1;
      case (bus.opcode)
        OP_LOAD: begin
          if (bus.funct3 == F3_BYTE || bus.funct3 == F3_WORD) begin
            dec_ctrl.regwrite = 1'b1;
            dec_ctrl.load     = 1'b1;
            dec_ctrl.byte_sz  = (bus.funct3 == F3_BYTE);
            dec_ctrl.alusrc   = 1'b1;
            dec_ctrl.memtoreg = 1'b1;
          end else begin
            dec_illegal = 1'b1;
          end
        end
        OP_STORE: begin
          if (bus.funct3 == F3_BYTE || bus.funct3 == F3_WORD) begin
            dec_ctrl.memwrite = 1'b1;
            dec_ctrl.byte_sz  = (bus.funct3 == F3_BYTE);
            dec_ctrl.alusrc   = 1'b1;
          end else begin
            dec_illegal = 1'b1;
          end
        end
        OP_IMM: begin
          if (bus.funct3 == F3_ADD) begin
            dec_ctrl.regwrite = 1'b1;
            dec_ctrl.alusrc   = 1'b1;
          end else begin
            dec_illegal = 1'b1;
          end
        end
        OP_REG: begin
          if (bus.funct3 == F3_ADD && bus.funct7 == F7_ADD) begin
            dec_ctrl.regwrite = 1'b1;
          end else if (bus.funct3 == F3_ADD && bus.funct7 == F7_SUB) begin
            dec_ctrl.regwrite = 1'b1;
            dec_ctrl.aluop    = ALU_SUB;
          end else if (bus.funct3 == F3_ADD && bus.funct7 == F7_MUL) begin
            dec_ctrl.regwrite = 1'b1;
            dec_ctrl.mul      = 1'b1;
            dec_ctrl.aluop    = ALU_MUL;
          end else begin
            dec_illegal = 1'b1;
          end
        end
        default: dec_illegal = 1'b1;
      endcase
    end
  end

  assign dec_word.illegal = dec_illegal;
  assign dec_word.ctrl    = dec_ctrl;

  assign mul_busy  = e_q.valid & e_q.mul & (cnt_q != '0);
  assign mul_abort = bus.flush_e & is_valid_mul(e_q);

  assign d_clr = bus.flush_d;
  assign d_en  = ~(bus.stall_d | mul_busy);

  // flush_e outranks the MUL hold; stall_d only bubbles E once E is free to take something.
  assign e_clr = bus.flush_e | (bus.stall_d & ~mul_busy);
  assign e_en  = ~mul_busy;

  assign m_clr = mul_busy | mul_abort;

  assign mul_enter = ~e_clr & e_en & is_valid_mul(d_q.ctrl);

  always_comb begin
    cnt_d = cnt_q;
    if (bus.flush_e) begin
      cnt_d = '0;
    end else if (mul_enter) begin
      cnt_d = CNT_W'(MUL_LAT - 1);
    end else if (mul_busy) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  ctrl_stage_reg #(.W($bits(dstage_t))) u_stage_d (
    .clk   (clk),
    .reset (reset),
    .en_i  (d_en),
    .clr_i (d_clr),
    .d_i   (dec_word),
    .q_o   (d_q)
  );

  ctrl_stage_reg #(.W($bits(ctrl_t))) u_stage_e (
    .clk   (clk),
    .reset (reset),
    .en_i  (e_en),
    .clr_i (e_clr),
    .d_i   (d_q.ctrl),
    .q_o   (e_q)
  );

  ctrl_stage_reg #(.W($bits(ctrl_t))) u_stage_m (
    .clk   (clk),
    .reset (reset),
    .en_i  (1'b1),
    .clr_i (m_clr),
    .d_i   (e_q),
    .q_o   (m_q)
  );

  ctrl_stage_reg #(.W($bits(ctrl_t))) u_stage_w (
    .clk   (clk),
    .reset (reset),
    .en_i  (1'b1),
    .clr_i (1'b0),
    .d_i   (m_q),
    .q_o   (w_q)
  );

  assign bus.load_d     = d_q.ctrl.load;
  assign bus.byte_d     = d_q.ctrl.byte_sz;
  assign bus.valid_d    = d_q.ctrl.valid;
  assign bus.illegal_d  = d_q.illegal;

  assign bus.alusrc_e   = e_q.alusrc;
  assign bus.mul_e      = e_q.mul;
  assign bus.valid_e    = e_q.valid;
  assign bus.aluop_e    = e_q.aluop;

  assign bus.memwrite_m = m_q.memwrite;
  assign bus.byte_m     = m_q.byte_sz;
  assign bus.valid_m    = m_q.valid;

  assign bus.regwrite_w = w_q.regwrite;
  assign bus.memtoreg_w = w_q.memtoreg;
  assign bus.byte_w     = w_q.byte_sz;
  assign bus.valid_w    = w_q.valid;

  assign bus.mul_busy   = mul_busy;

  // W-stage fields with no consumer downstream of the control unit.
  logic unused_w_fields;
  assign unused_w_fields = ^{w_q.memwrite, w_q.load, w_q.alusrc, w_q.mul, w_q.aluop};

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: decode table, hand-written hazard sequences, then random traffic vs a reference model.
module tb_pipe_ctrl_unit;

  localparam int MUL_LAT = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_unit_if bus ();

  pipe_ctrl_unit #(.MUL_LAT(MUL_LAT), .CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // {vld, opcode, funct3, funct7}
  localparam logic [17:0] I_NOP  = 18'd0;
  localparam logic [17:0] I_LB   = {1'b1, 7'b0000011, 3'd0, 7'd0};
  localparam logic [17:0] I_LW   = {1'b1, 7'b0000011, 3'd2, 7'd0};
  localparam logic [17:0] I_SB   = {1'b1, 7'b0100011, 3'd0, 7'd0};
  localparam logic [17:0] I_SW   = {1'b1, 7'b0100011, 3'd2, 7'd0};
  localparam logic [17:0] I_ADDI = {1'b1, 7'b0010011, 3'd0, 7'd0};
  localparam logic [17:0] I_ADD  = {1'b1, 7'b0110011, 3'd0, 7'd0};
  localparam logic [17:0] I_SUB  = {1'b1, 7'b0110011, 3'd0, 7'h20};
  localparam logic [17:0] I_MUL  = {1'b1, 7'b0110011, 3'd0, 7'h01};
  localparam logic [17:0] I_BAD  = {1'b1, 7'h7F, 3'd0, 7'd0};

  // Reference model: one record per stage, plus remaining extra E cycles for a MUL.
  typedef struct packed {
    bit v; bit ill; bit rw; bit mw; bit ld; bit by; bit as_; bit m2r; bit mu; bit [2:0] op;
  } mstage_t;

  mstage_t md = '0, me = '0, mm = '0, mw = '0;
  int e_left = 0;

  function automatic mstage_t ref_decode(logic [17:0] ins);
    mstage_t r = '0;
    bit [6:0] op = ins[16:10];
    bit [2:0] f3 = ins[9:7];
    bit [6:0] f7 = ins[6:0];
    if (!ins[17]) return r;
    r.v = 1'b1;
    if (op == 7'b0000011 && (f3 == 3'd0 || f3 == 3'd2)) begin
      r.rw = 1; r.ld = 1; r.as_ = 1; r.m2r = 1; r.by = (f3 == 3'd0);
    end else if (op == 7'b0100011 && (f3 == 3'd0 || f3 == 3'd2)) begin
      r.mw = 1; r.as_ = 1; r.by = (f3 == 3'd0);
    end else if (op == 7'b0010011 && f3 == 3'd0) begin
      r.rw = 1; r.as_ = 1;
    end else if (op == 7'b0110011 && f3 == 3'd0 && (f7 == 7'h00 || f7 == 7'h20 || f7 == 7'h01)) begin
      r.rw = 1;
      r.mu = (f7 == 7'h01);
      r.op = (f7 == 7'h20) ? 3'd1 : (f7 == 7'h01) ? 3'd2 : 3'd0;
    end else begin
      r.ill = 1;
    end
    return r;
  endfunction

  task automatic model_step();
    mstage_t nd, ne, nm, nw;
    int nl;
    bit busy;
    busy = me.v && me.mu && (e_left > 0);
    nl = 0;
    if (!reset) begin
      nd = '0; ne = '0; nm = '0; nw = '0;
    end else begin
      nw = mm;
      nm = (busy || (bus.flush_e && me.v && me.mu)) ? '0 : me;
      if (bus.flush_e) ne = '0;
      else if (busy) begin ne = me; nl = e_left - 1; end
      else if (bus.stall_d) ne = '0;
      else begin ne = md; nl = (md.v && md.mu) ? MUL_LAT - 1 : 0; end
      if (bus.flush_d) nd = '0;
      else if (bus.stall_d || busy) nd = md;
      else nd = ref_decode({bus.instr_vld_f, bus.opcode, bus.funct3, bus.funct7});
    end
    md = nd; me = ne; mm = nm; mw = nw; e_left = nl;
  endtask

  function automatic logic [17:0] model_out();
    return {md.ld, md.by, md.v, md.ill, me.as_, me.mu, me.v, me.op,
            mm.mw, mm.by, mm.v, mw.rw, mw.m2r, mw.by, mw.v,
            logic'(me.v && me.mu && (e_left > 0))};
  endfunction

  function automatic logic [17:0] dut_out();
    return {bus.load_d, bus.byte_d, bus.valid_d, bus.illegal_d,
            bus.alusrc_e, bus.mul_e, bus.valid_e, bus.aluop_e,
            bus.memwrite_m, bus.byte_m, bus.valid_m,
            bus.regwrite_w, bus.memtoreg_w, bus.byte_w, bus.valid_w, bus.mul_busy};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic [17:0] ins, bit st = 0, bit fd = 0, bit fe = 0);
    {bus.instr_vld_f, bus.opcode, bus.funct3, bus.funct7} = ins;
    bus.stall_d = st;
    bus.flush_d = fd;
    bus.flush_e = fe;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    drive(I_NOP);
    repeat (6) tick();
  endtask

  typedef struct {
    string       name;
    logic [17:0] ins;
    logic [3:0]  exp_d;   // load, byte, illegal, valid
    logic [5:0]  exp_e;   // alusrc, mul, valid, aluop
    logic        exp_mw;
    logic [2:0]  exp_w;   // regwrite, memtoreg, byte
    logic        reaches;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [17:0] ins;
    bit m_seen, w_seen, mw_cap;
    logic [2:0] w_cap;

    vecs[0]  = '{"LB",    I_LB,   4'b1101, 6'b101_000, 1'b0, 3'b111, 1'b1};
    vecs[1]  = '{"LW",    I_LW,   4'b1001, 6'b101_000, 1'b0, 3'b110, 1'b1};
    vecs[2]  = '{"SB",    I_SB,   4'b0101, 6'b101_000, 1'b1, 3'b001, 1'b1};
    vecs[3]  = '{"SW",    I_SW,   4'b0001, 6'b101_000, 1'b1, 3'b000, 1'b1};
    vecs[4]  = '{"ADDI",  I_ADDI, 4'b0001, 6'b101_000, 1'b0, 3'b100, 1'b1};
    vecs[5]  = '{"ADD",   I_ADD,  4'b0001, 6'b001_000, 1'b0, 3'b100, 1'b1};
    vecs[6]  = '{"SUB",   I_SUB,  4'b0001, 6'b001_001, 1'b0, 3'b100, 1'b1};
    vecs[7]  = '{"MUL",   I_MUL,  4'b0001, 6'b011_010, 1'b0, 3'b100, 1'b1};
    vecs[8]  = '{"OP7F",  I_BAD,  4'b0011, 6'b001_000, 1'b0, 3'b000, 1'b1};
    vecs[9]  = '{"LD_F1", {1'b1, 7'b0000011, 3'd1, 7'd0}, 4'b0011, 6'b001_000, 1'b0, 3'b000, 1'b1};
    vecs[10] = '{"R_F7",  {1'b1, 7'b0110011, 3'd0, 7'h02}, 4'b0011, 6'b001_000, 1'b0, 3'b000, 1'b1};
    vecs[11] = '{"NOVLD", {1'b0, 7'b0000011, 3'd2, 7'd0}, 4'b0000, 6'b000_000, 1'b0, 3'b000, 1'b0};

    // 1: reset held two cycles with LW on the inputs
    reset = 1'b0;
    drive(I_LW);
    tick();
    check("rst_c1_outs", dut_out(), 18'd0);
    tick();
    check("rst_c2_outs", dut_out(), 18'd0);
    reset = 1'b1;
    tick();
    check("rst_release_lw_d", {bus.load_d, bus.valid_d}, 2'b11);
    drain();

    // Decode table: each entry alone through the pipe
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].ins);
      tick();
      check({vecs[i].name, "_d"}, {bus.load_d, bus.byte_d, bus.illegal_d, bus.valid_d}, vecs[i].exp_d);
      drive(I_NOP);
      tick();
      check({vecs[i].name, "_e"}, {bus.alusrc_e, bus.mul_e, bus.valid_e, bus.aluop_e}, vecs[i].exp_e);
      m_seen = 0; w_seen = 0; mw_cap = 0; w_cap = 3'b000;
      for (int c = 0; c < 8; c++) begin
        tick();
        if (bus.valid_m && !m_seen) begin m_seen = 1; mw_cap = bus.memwrite_m; end
        if (bus.valid_w && !w_seen) begin w_seen = 1; w_cap = {bus.regwrite_w, bus.memtoreg_w, bus.byte_w}; end
      end
      check({vecs[i].name, "_mw"}, {m_seen, mw_cap, w_seen, w_cap},
            {vecs[i].reaches, vecs[i].exp_mw, vecs[i].reaches, vecs[i].exp_w});
    end
    drain();

    // 2: LW walking the stages
    drive(I_LW);
    tick();
    check("lw_c1", {bus.load_d, bus.byte_d, bus.valid_d}, 3'b101);
    drive(I_NOP);
    tick();
    check("lw_c2", {bus.alusrc_e, bus.aluop_e, bus.valid_e}, 5'b1_000_1);
    tick();
    check("lw_c3", {bus.memwrite_m, bus.valid_m}, 2'b01);
    tick();
    check("lw_c4", {bus.regwrite_w, bus.memtoreg_w, bus.valid_w}, 3'b111);
    drain();

    // 3: MUL then ADD
    drive(I_MUL);
    tick();
    drive(I_ADD);
    tick();
    check("mul_t0", {bus.mul_busy, bus.mul_e, bus.valid_d}, 3'b111);
    tick();
    check("mul_t1", {bus.mul_busy, bus.valid_m, bus.valid_d, bus.valid_e}, 4'b1011);
    tick();
    check("mul_t2", {bus.mul_busy, bus.valid_m, bus.valid_d, bus.mul_e}, 4'b0011);
    drive(I_NOP);
    tick();
    check("mul_t3", {bus.valid_m, bus.valid_e, bus.mul_e, bus.aluop_e, bus.mul_busy}, 7'b11_0_000_0);
    tick();
    check("mul_t4", {bus.regwrite_w, bus.valid_w}, 2'b11);
    tick();
    check("add_w", {bus.regwrite_w, bus.valid_w}, 2'b11);
    drain();

    // 4: SW held in D by one stall cycle
    drive(I_SW);
    tick();
    drive(I_NOP, 1);
    tick();
    check("sw_stall", {bus.valid_d, bus.valid_e}, 2'b10);
    drive(I_NOP);
    tick();
    check("sw_e", {bus.valid_e, bus.memwrite_m}, 2'b10);
    tick();
    check("sw_m", {bus.memwrite_m, bus.valid_m}, 2'b11);
    drain();

    // 5: flush_e aborts MUL on its first busy cycle
    drive(I_MUL);
    tick();
    drive(I_ADD);
    tick();
    check("flush_mul_busy", bus.mul_busy, 1'b1);
    drive(I_ADD, 0, 0, 1);
    tick();
    check("flush_mul_after", {bus.mul_busy, bus.valid_e, bus.valid_m, bus.valid_d}, 4'b0001);
    drive(I_NOP);
    tick();
    check("flush_add_e", {bus.valid_e, bus.mul_e, bus.valid_m, bus.valid_w}, 4'b1000);
    tick();
    check("flush_add_m", {bus.valid_m, bus.valid_w}, 2'b10);
    tick();
    check("flush_add_w", {bus.regwrite_w, bus.valid_w}, 2'b11);
    drain();

    // 6: illegal opcode, then stall_d and flush_d together
    drive(I_BAD);
    tick();
    check("ill_d", {bus.illegal_d, bus.valid_d, bus.load_d, bus.byte_d}, 4'b1100);
    drive(I_NOP, 1, 1, 0);
    tick();
    check("ill_flush", {bus.valid_d, bus.illegal_d, bus.valid_e}, 3'b000);
    drive(I_NOP);
    drain();

    // Random traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 11))
        0: ins = I_LB;   1: ins = I_LW;  2: ins = I_SB;  3: ins = I_SW;
        4: ins = I_ADDI; 5: ins = I_ADD; 6: ins = I_SUB;
        7, 8: ins = I_MUL;
        9: ins = {1'b1, 7'($urandom), 3'($urandom), 7'($urandom)};
        10: ins = {1'b0, 17'($urandom)};
        default: ins = I_NOP;
      endcase
      reset = ($urandom_range(0, 80) != 0);
      drive(ins, ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0));
      tick();
      check("rand", dut_out(), model_out());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
